// File: rtl/sram_1p_bwe_pkg.sv
// Shared types and helpers for the single-port byte-write SRAM model.
package sram_pkg;

  // Widest word/lane count the mask helper can expand; callers size-cast down.
  localparam int MAX_BITS = 1024;
  localparam int MAX_NL   = 1024;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } sram_state_e;

  // Number of write-mask lanes in a word.
  function automatic int lanes(input int bits, input int lane_w);
    return bits / lane_w;
  endfunction

  // Turn active-low lane enables into an active-high per-bit write mask.
  function automatic logic [MAX_BITS-1:0] mask_expand(input logic [MAX_NL-1:0] bweb,
                                                       input int lane_w);
    logic [MAX_BITS-1:0] m;
    m = {MAX_BITS{1'b0}};
    for (int b = 0; b < MAX_BITS; b++) begin
      m[10'(b)] = ~bweb[10'(b / lane_w)];
    end
    return m;
  endfunction

endpackage

// File: rtl/sram_1p_bwe_if.sv
// Access bus of the single-port SRAM: active-low controls, data and status.
interface sram_1p_bwe_if
  import sram_pkg::*;
#(
  parameter int BITS   = 64,
  parameter int ADDR_W = 7,
  parameter int LANE_W = 8
);
  localparam int NL = lanes(BITS, LANE_W);

  logic              CEB;
  logic              WEB;
  logic [NL-1:0]     BWEB;
  logic [ADDR_W-1:0] A;
  logic [BITS-1:0]   D;
  logic [BITS-1:0]   Q;
  logic              QV;
  logic              BUSY;

  modport master (output CEB, WEB, BWEB, A, D, input Q, QV, BUSY);
  modport slave  (input CEB, WEB, BWEB, A, D, output Q, QV, BUSY);
endinterface

// File: rtl/sram_1p_bwe_array.sv
// Storage core: masked write and registered read, no reset on contents or read data.
module sram_1p_array #(
  parameter int BITS   = 64,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              i_clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [BITS-1:0]   i_wdata,
  input  logic [BITS-1:0]   i_mask,
  output logic [BITS-1:0]   o_rdata
);
  logic [BITS-1:0] r_mem [DEPTH];
  logic            w_in_range;

  // Addresses past the last word exist only when DEPTH is not a power of two.
  assign w_in_range = (32'(i_addr) < DEPTH);

  // Masked write: only lanes enabled in i_mask take the new data.
  always_ff @(posedge i_clk) begin
    if (i_en && i_we && w_in_range) begin
      r_mem[i_addr] <= (r_mem[i_addr] & ~i_mask) | (i_wdata & i_mask);
    end
  end

  // Registered read; holds between reads, out-of-range reads return zero.
  always_ff @(posedge i_clk) begin
    if (i_en && !i_we) begin
      o_rdata <= w_in_range ? r_mem[i_addr] : {BITS{1'b0}};
    end
  end
endmodule

// File: rtl/sram_1p_bwe.sv
// Single-port SRAM with lane write mask, optional output register, read-valid
// strobe and a zero-fill sweep after reset.
module sram_1p_bwe
  import sram_pkg::*;
#(
  parameter int BITS      = 64,
  parameter int DEPTH     = 128,
  parameter int ADDR_W    = 7,
  parameter int LANE_W    = 8,
  parameter int OUT_REG   = 0,
  parameter int INIT_ZERO = 1
) (
  input  logic         CLK,
  input  logic         RSTB,
  sram_1p_bwe_if.slave bus
);
  sram_state_e       r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_busy;
  logic              r_v1;
  logic              r_v2;
  logic              r_have;
  logic [BITS-1:0]   r_q2;

  logic              w_init_wr;
  logic              w_user;
  logic              w_rd_fire;
  logic              w_en;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [BITS-1:0]   w_wdata;
  logic [BITS-1:0]   w_mask;
  logic [BITS-1:0]   w_user_mask;
  logic [BITS-1:0]   w_rdata;

  assign w_init_wr   = (r_state == INIT);
  // User accesses are blocked for the whole time BUSY is visible.
  assign w_user      = ~r_busy & ~bus.CEB;
  assign w_rd_fire   = w_user & bus.WEB;
  assign w_user_mask = BITS'(mask_expand(MAX_NL'(bus.BWEB), LANE_W));

  // Init FSM: sweep zeros through every word, BUSY trails the state by one edge.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_state <= (INIT_ZERO != 0) ? INIT : RUN;
      r_cnt   <= {ADDR_W{1'b0}};
      r_busy  <= (INIT_ZERO != 0);
    end else begin
      r_busy <= (r_state == INIT);
      case (r_state)
        INIT: begin
          if (r_cnt == ADDR_W'(DEPTH - 1)) begin
            r_state <= RUN;
            r_cnt   <= {ADDR_W{1'b0}};
          end else begin
            r_cnt <= r_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end
        RUN:     r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end

  // Access mux: the sweep owns the array while it runs.
  always_comb begin
    if (w_init_wr) begin
      w_en    = 1'b1;
      w_we    = 1'b1;
      w_addr  = r_cnt;
      w_wdata = {BITS{1'b0}};
      w_mask  = {BITS{1'b1}};
    end else begin
      w_en    = w_user;
      w_we    = ~bus.WEB;
      w_addr  = bus.A;
      w_wdata = bus.D;
      w_mask  = w_user_mask;
    end
  end

  sram_1p_array #(
    .BITS   (BITS),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .i_clk   (CLK),
    .i_en    (w_en),
    .i_we    (w_we),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .i_mask  (w_mask),
    .o_rdata (w_rdata)
  );

  // Read-valid pipeline and optional output register; reset drops in-flight reads.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_have <= 1'b0;
      r_q2   <= {BITS{1'b0}};
    end else begin
      r_v1 <= w_rd_fire;
      r_v2 <= r_v1;
      if (w_rd_fire) begin
        r_have <= 1'b1;
      end
      if (r_v1) begin
        r_q2 <= w_rdata;
      end
    end
  end

  // Array read data has no reset, so Q is forced to zero until the first read.
  assign bus.Q    = (OUT_REG != 0) ? r_q2 : (r_have ? w_rdata : {BITS{1'b0}});
  assign bus.QV   = (OUT_REG != 0) ? r_v2 : r_v1;
  assign bus.BUSY = r_busy;
endmodule
